multiplicador_seq16: RTL and testbench
======================================

# multiplicador_seq16

Sequential shift-and-add unsigned multiplier, 8×8 → 16 bits, built around the 16-bit logical left shifter (`DeslocaEsq16`) as its multiplicand-shift stage. The block registers two operands on a start pulse and iterates once per clock for 8 cycles. In each cycle it conditionally accumulates the shifted multiplicand, shifts the multiplicand left through the shifter instance, and shifts the multiplier right. It drives the left shifter's input every cycle and consumes its output as the next multiplicand value.

## Interface
- `N`, default 8: operand width. The product is 2N bits. Only N = 8 is supported, because the shifter instance is fixed at 16 bits.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `inicio`  input  1  start request; sampled only in state OCIOSO.
- `A`  input  8  multiplicand; captured on the accepted start edge.
- `B`  input  8  multiplier; captured on the accepted start edge.
- `produto`  output  16  result register; holds the last completed product.
- `ocupado`  output  1  high while in state CALCULA.
- `pronto`  output  1  one-cycle completion pulse; high only in state FIM.

## Operation
- Internal registers:
  - `mcand` (16 bits)
  - `mplier` (8 bits)
  - `acc` (16 bits)
  - `cont` (3 bits)
  - state register (3 states)
- Reset (`rst` = 1 at an edge):
  - State becomes OCIOSO.
  - `produto` = 0x0000, `ocupado` = 0, `pronto` = 0.
  - `mcand`, `mplier`, `acc` and `cont` are all cleared to 0.
- OCIOSO:
  - If `inicio` = 1: `mcand` ← {8'h00, A}, `mplier` ← B, `acc` ← 0, `cont` ← 0, and the next state is CALCULA.
  - Otherwise all registers hold.
- CALCULA, one iteration per edge:
  - If `mplier[0]` = 1: `acc` ← `acc` + `mcand`, truncated to 16 bits. No overflow is possible for 8×8 operands.
  - `mcand` ← output of `DeslocaEsq16(mcand)`: MSB discarded, LSB zero-filled.
  - `mplier` ← {1'b0, `mplier[7:1]`}.
  - `cont` ← `cont` + 1.
  - When `cont` = 7 at the edge, the iteration completes as above, `produto` ← the final `acc` value (including that iteration's add), and the next state is FIM.
- FIM: lasts exactly one cycle, then the state unconditionally returns to OCIOSO.
- Fixed iteration count: there is no early exit when `mplier` becomes 0. Latency is identical for every operand pair.
- `inicio` in CALCULA or FIM is ignored and not queued. Changes to `A`/`B` after the accepted start edge have no effect.
- `produto` changes only on the CALCULA→FIM edge and on reset. It holds its value through the following OCIOSO and through the next operation until that operation completes.
- Reset mid-operation: the operation is aborted. All outputs take their reset values on that edge, no `pronto` pulse is emitted, and the previous `produto` is lost (0x0000).
- If `rst` and `inicio` are both high on the same edge, `rst` wins and the start is not accepted.

## Timing
- Edge E0: `inicio` = 1 sampled in OCIOSO. `ocupado` = 1 from E0 until E8.
- Edges E1–E8: iterations 0–7. On E8, `produto` is updated, `ocupado` → 0 and `pronto` → 1.
- Edge E9: `pronto` → 0 and the state returns to OCIOSO. The earliest next accepted start is E10, so back-to-back throughput is one product per 10 cycles.
- `ocupado` and `pronto` are never high simultaneously. Both are registered state decodes, with no combinational path from the inputs.
- Outputs are registered only. The shifter and adder form the single-cycle combinational path `mcand` → `acc`/`mcand`.

## Test plan
- Reset, then A = 0xFF, B = 0xFF, `inicio` pulsed at E0 → `ocupado` high from E0 to E8, `pronto` high exactly between E8 and E9, `produto` = 0xFE01 from E8.
- A = 0x00, B = 0xB7 → `produto` = 0x0000 and `pronto` still asserted after E8 (no early exit). Then A = 0x01, B = 0xAB → `produto` = 0x00AB.
- Back-to-back: A = 0x12, B = 0x34 → `produto` = 0x03A8. `inicio` held high throughout, so the second start (A = 0x80, B = 0x02) is accepted at E10 → `produto` = 0x0100 at E18. `produto` stays 0x03A8 from E8 until E18.
- Start with A = 0x0F, B = 0x0F, then pulse `inicio` and change A/B to 0xFF during CALCULA and during FIM → both ignored, and `produto` = 0x00E1.
- Complete 0x03 × 0x05 (`produto` = 0x000F), then start 0xFF × 0xFF and assert `rst` at E4 → `produto` = 0x0000, `ocupado` = 0, `pronto` never asserted. Then `rst` and `inicio` high on the same edge → the block remains in OCIOSO.

Source files
------------

// File: rtl/multiplicador_seq16.sv
// Sequential shift-and-add unsigned multiplier, 8x8 -> 16 bits.
// The multiplicand is shifted through a 16-bit logical left shifter once per iteration.

module DeslocaEsq16 (
  input  logic [15:0] dado_i,
  output logic [15:0] dado_o
);
  assign dado_o = {dado_i[14:0], 1'b0};
endmodule

module multiplicador_seq16 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inicio,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] produto,
  output logic           ocupado,
  output logic           pronto
);

  typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

  estado_t        estado_q;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2:0]     cont_q, cont_d;
  logic [2*N-1:0] produto_q;
  logic           ocupado_q, pronto_q;

  DeslocaEsq16 u_desloca (
    .dado_i (mcand_q),
    .dado_o (mcand_d)
  );

  // One iteration: conditional add, multiplier shifted right, counter advanced.
  always_comb begin
    acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mplier_d = {1'b0, mplier_q[N-1:1]};
    cont_d   = cont_q + 3'd1;
  end

  // Fixed eight-iteration run; no early exit, so latency never depends on operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cont_q    <= '0;
      produto_q <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          pronto_q <= 1'b0;
          if (inicio) begin
            mcand_q   <= {{N{1'b0}}, A};
            mplier_q  <= B;
            acc_q     <= '0;
            cont_q    <= '0;
            ocupado_q <= 1'b1;
            estado_q  <= CALCULA;
          end
        end
        CALCULA: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cont_q   <= cont_d;
          if (cont_q == 3'd7) begin
            produto_q <= acc_d;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b1;
            estado_q  <= FIM;
          end
        end
        FIM: begin
          pronto_q <= 1'b0;
          estado_q <= OCIOSO;
        end
        default: begin
          ocupado_q <= 1'b0;
          pronto_q  <= 1'b0;
          estado_q  <= OCIOSO;
        end
      endcase
    end
  end

  assign produto = produto_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_multiplicador_seq16.sv
// Directed testbench for multiplicador_seq16: timing, products, start filtering and reset abort.

module tb_multiplicador_seq16;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [7:0]  A, B;
  logic [15:0] produto;
  logic        ocupado, pronto;

  int checks = 0;
  int errors = 0;
  logic [15:0] lastProd = 16'h0000;

  multiplicador_seq16 #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .produto (produto),
    .ocupado (ocupado),
    .pronto  (pronto)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; inicio = 1'b0; A = 8'h00; B = 8'h00;
    tick(); tick();
    checks++;
    if (produto !== 16'h0000) begin errors++; $display("[TB] FAIL reset_produto got %h want 0000", produto); end
    checks++;
    if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL reset_ocupado got %b want 0", ocupado); end
    checks++;
    if (pronto !== 1'b0) begin errors++; $display("[TB] FAIL reset_pronto got %b want 0", pronto); end
    rst = 1'b0;
    tick();
    lastProd = 16'h0000;
  endtask

  // Full operation from E0 to E9 with timing and hold checks on every edge.
  task automatic test_multiply(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    A = a; B = b; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    checks++;
    if (ocupado !== 1'b1 || pronto !== 1'b0) begin
      errors++; $display("[TB] FAIL start_E0 ocupado=%b pronto=%b want 1/0", ocupado, pronto);
    end
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (ocupado !== 1'b1 || pronto !== 1'b0 || produto !== lastProd) begin
        errors++;
        $display("[TB] FAIL busy_E%0d ocupado=%b pronto=%b produto=%h want 1/0/%h", e, ocupado, pronto, produto, lastProd);
      end
    end
    tick();
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b1 || produto !== exp) begin
      errors++;
      $display("[TB] FAIL done_E8 %h*%h ocupado=%b pronto=%b produto=%h want 0/1/%h", a, b, ocupado, pronto, produto, exp);
    end
    tick();
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0 || produto !== exp) begin
      errors++;
      $display("[TB] FAIL idle_E9 ocupado=%b pronto=%b produto=%h want 0/0/%h", ocupado, pronto, produto, exp);
    end
    lastProd = exp;
  endtask

  task automatic test_back_to_back;
    A = 8'h12; B = 8'h34; inicio = 1'b1;
    tick();
    A = 8'h80; B = 8'h02;
    for (int e = 1; e <= 7; e++) tick();
    tick();
    checks++;
    if (pronto !== 1'b1 || produto !== 16'h03A8) begin
      errors++; $display("[TB] FAIL b2b_first pronto=%b produto=%h want 1/03A8", pronto, produto);
    end
    tick();
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_E9 ocupado=%b pronto=%b want 0/0", ocupado, pronto);
    end
    tick();
    checks++;
    if (ocupado !== 1'b1 || produto !== 16'h03A8) begin
      errors++; $display("[TB] FAIL b2b_E10 ocupado=%b produto=%h want 1/03A8", ocupado, produto);
    end
    inicio = 1'b0;
    for (int e = 11; e <= 17; e++) begin
      tick();
      checks++;
      if (produto !== 16'h03A8 || ocupado !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_hold_E%0d produto=%h ocupado=%b want 03A8/1", e, produto, ocupado);
      end
    end
    tick();
    checks++;
    if (pronto !== 1'b1 || produto !== 16'h0100) begin
      errors++; $display("[TB] FAIL b2b_second pronto=%b produto=%h want 1/0100", pronto, produto);
    end
    tick();
    lastProd = 16'h0100;
  endtask

  task automatic test_ignore_inputs;
    A = 8'h0F; B = 8'h0F; inicio = 1'b1;
    tick();
    inicio = 1'b0; A = 8'hFF; B = 8'hFF;
    tick(); tick();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    for (int e = 4; e <= 8; e++) tick();
    checks++;
    if (pronto !== 1'b1 || produto !== 16'h00E1) begin
      errors++; $display("[TB] FAIL ignore_result pronto=%b produto=%h want 1/00E1", pronto, produto);
    end
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0 || produto !== 16'h00E1) begin
      errors++; $display("[TB] FAIL ignore_not_queued ocupado=%b pronto=%b produto=%h want 0/0/00E1", ocupado, pronto, produto);
    end
    lastProd = 16'h00E1;
  endtask

  task automatic test_reset_abort;
    A = 8'hFF; B = 8'hFF; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (produto !== 16'h0000 || ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_E4 produto=%h ocupado=%b pronto=%b want 0000/0/0", produto, ocupado, pronto);
    end
    for (int e = 5; e <= 12; e++) begin
      tick();
      checks++;
      if (pronto !== 1'b0 || ocupado !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_quiet_E%0d pronto=%b ocupado=%b want 0/0", e, pronto, ocupado);
      end
    end
    rst = 1'b1; inicio = 1'b1; A = 8'h03; B = 8'h03;
    tick();
    rst = 1'b0; inicio = 1'b0;
    checks++;
    if (ocupado !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_wins_edge ocupado=%b want 0", ocupado);
    end
    tick();
    checks++;
    if (ocupado !== 1'b0 || produto !== 16'h0000) begin
      errors++; $display("[TB] FAIL rst_wins_idle ocupado=%b produto=%h want 0/0000", ocupado, produto);
    end
    lastProd = 16'h0000;
  endtask

  initial begin
    $display("[TB] starting multiplicador_seq16 tests");
    test_reset();
    test_multiply(8'hFF, 8'hFF, 16'hFE01);
    test_multiply(8'h00, 8'hB7, 16'h0000);
    test_multiply(8'h01, 8'hAB, 16'h00AB);
    test_back_to_back();
    test_ignore_inputs();
    test_multiply(8'h03, 8'h05, 16'h000F);
    test_reset_abort();
    test_multiply(8'h01, 8'hAB, 16'h00AB);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
